// File: rtl/shift_pkg.sv
// Shared types and helpers for the shift arbiter slice: request bundle,
// requester ids and the 32-bit bit reversal used to build left shifts.
package shift_pkg;

    localparam int SHIFT_W = 32;
    localparam int REQ_ALU = 0;
    localparam int REQ_LSU = 1;

    typedef struct packed {
        logic [SHIFT_W-1:0] a;
        logic [4:0]         b;
        logic               arith;
        logic               left;
    } shift_req_t;

    function automatic logic [SHIFT_W-1:0] bit_reverse32(input logic [SHIFT_W-1:0] x);
        logic [SHIFT_W-1:0] r;
        for (int i = 0; i < SHIFT_W; i++)
            r[i] = x[SHIFT_W-1-i];
        return r;
    endfunction

endpackage

// File: rtl/shift_arbiter_shr.sv
// Combinational 32-bit right shifter, logical or arithmetic, 5-bit amount.
module shift_arbiter_shr
    import shift_pkg::*;
(
    input  logic [SHIFT_W-1:0] a,
    input  logic [4:0]         amt,
    input  logic               arith,
    output logic [SHIFT_W-1:0] y
);

    always_comb begin
        if (arith)
            y = $unsigned($signed(a) >>> amt);
        else
            y = a >> amt;
    end

endmodule

// File: rtl/shift_arbiter.sv
// Two-requester front end for one shared right shifter: arbitration,
// bit-reversal for left shifts, and a one-entry registered result stage.
module shift_arbiter
    import shift_pkg::*;
#(
    parameter bit ROUND_ROBIN = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  req_valid,
    output logic [1:0]  req_ready,
    input  logic [63:0] req_a,
    input  logic [9:0]  req_b,
    input  logic [1:0]  req_arith,
    input  logic [1:0]  req_left,
    output logic [1:0]  rsp_valid,
    input  logic [1:0]  rsp_ready,
    output logic        rsp_id,
    output logic [31:0] rsp_data
);

    shift_req_t         reqs [2];
    shift_req_t         sel;
    logic [1:0]         gnt;
    logic               gid;
    logic               free;
    logic               ptr;
    logic               entry_valid;
    logic               id_q;
    logic [SHIFT_W-1:0] data_q;
    logic [SHIFT_W-1:0] sh_in;
    logic [SHIFT_W-1:0] sh_out;
    logic [SHIFT_W-1:0] result;

    always_comb begin
        reqs[REQ_ALU] = '{a: req_a[31:0],  b: req_b[4:0], arith: req_arith[0], left: req_left[0]};
        reqs[REQ_LSU] = '{a: req_a[63:32], b: req_b[9:5], arith: req_arith[1], left: req_left[1]};
    end

    // rsp_valid[rsp_id] is exactly entry_valid, so only the owner's ready matters
    assign free = !entry_valid || rsp_ready[id_q];

    always_comb begin
        gnt = 2'b00;
        if (free) begin
            if (ROUND_ROBIN) begin
                if (req_valid[ptr])
                    gnt[ptr] = 1'b1;
                else if (req_valid[~ptr])
                    gnt[~ptr] = 1'b1;
            end else begin
                if (req_valid[0])
                    gnt[0] = 1'b1;
                else if (req_valid[1])
                    gnt[1] = 1'b1;
            end
        end
    end

    assign gid       = gnt[1];
    assign req_ready = gnt;
    assign sel       = reqs[gid];

    // Left shift = reverse, logical right shift, reverse back
    assign sh_in  = sel.left ? bit_reverse32(sel.a) : sel.a;
    assign result = sel.left ? bit_reverse32(sh_out) : sh_out;

    shift_arbiter_shr u_shr (
        .a     (sh_in),
        .amt   (sel.b),
        .arith (sel.arith & ~sel.left),
        .y     (sh_out)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            entry_valid <= 1'b0;
            id_q        <= 1'b0;
            data_q      <= '0;
            ptr         <= 1'b0;
        end else if (|gnt) begin
            entry_valid <= 1'b1;
            id_q        <= gid;
            data_q      <= result;
            ptr         <= ~gid;
        end else if (free) begin
            entry_valid <= 1'b0;
        end
    end

    assign rsp_valid = entry_valid ? (id_q ? 2'b10 : 2'b01) : 2'b00;
    assign rsp_id    = id_q;
    assign rsp_data  = data_q;

endmodule

// File: doc/shift_arbiter.md
Name: shift_arbiter

Overview:
- Shares one 32-bit combinational right shifter (arith/logical, 5-bit amount) between two requesters, e.g. the integer ALU (requester 0) and the load/store byte-alignment path (requester 1).
- Adds left shifts by bit-reversing around the shifter.
- Per-requester valid/ready handshakes, round-robin or fixed-priority arbitration, and a one-entry registered result stage.
- Latency is 1 cycle, with throughput of 1 result per cycle.

Parameters:
- ROUND_ROBIN, 1, 1 = round-robin between requesters; 0 = fixed priority, requester 0 highest.

Ports:
- clk  input  1  system clock; all state on rising edge.
- rst  input  1  asynchronous, active-high reset.
- req_valid  input  2  per-requester request valid; bit i = requester i.
- req_ready  output  2  per-requester grant; handshake when req_valid[i] & req_ready[i].
- req_a  input  64  operand; bits [32i+31:32i] = requester i.
- req_b  input  10  shift amount; bits [5i+4:5i] = requester i.
- req_arith  input  2  1 = arithmetic right shift; ignored for left shifts.
- req_left  input  2  1 = logical left shift.
- rsp_valid  output  2  one-hot result valid; only bit rsp_id may be set.
- rsp_ready  input  2  per-requester result accept.
- rsp_id  output  1  requester owning the current result.
- rsp_data  output  32  shifted result, shared bus.

Behaviour:
- Reset (async): rsp_valid=0, rsp_id=0, rsp_data=0, priority pointer=0 (requester 0 preferred). req_ready is combinational and therefore 0 while rsp stage full and not draining. An in-flight result is dropped on reset; nothing is replayed.
- Result stage:
  - Holds one entry.
  - free = !entry_valid | (rsp_valid[rsp_id] & rsp_ready[rsp_id]).
- Arbitration (combinational):
  - If !free, req_ready=0.
  - Otherwise grant at most one requester with req_valid set.
  - ROUND_ROBIN=1: prefer the pointer requester; if it is idle, grant the other.
  - ROUND_ROBIN=0: requester 0 always wins.
- req_ready depends on req_valid; requesters must not make req_valid depend on req_ready.
- Pointer update: on any grant to i, pointer <= ~i. The pointer is unchanged when there is no grant.
- Datapath for the granted requester g:
  - Right shift: result = a >> b (logical) or a >>> b (arithmetic, sign = a[31]).
  - Left shift: result = rev(shr_logical(rev(a), b)). req_arith is ignored.
  - b=0 passes a through unchanged. b=31 is the maximum; there is no wrap or modulo beyond 5 bits.
- Registering: on grant in cycle N, rsp_data/rsp_id load and entry_valid=1 at edge end of N. rsp_valid[g]=1 in cycle N+1.
- Draining:
  - Handshake: entry clears unless a new grant occurs in the same cycle.
  - Simultaneous drain and grant: the new entry overwrites, keeping back-to-back 1/cycle.
- Stall: while rsp_ready[rsp_id]=0, rsp_data/rsp_id/rsp_valid are held stable and req_ready=0.
- rsp_ready of the non-owning requester is ignored.
- Requester inputs are sampled only in the grant cycle; they need not stay stable afterwards.

Decomposition:
- Shared package shift_pkg:
  - typedef shift_req_t {a[31:0], b[4:0], arith, left}.
  - constant SHIFT_W=32; localparams REQ_ALU=0, REQ_LSU=1.
  - function bit_reverse32.
- One sub-module: the existing right-shifter, instantiated once on the muxed operands. Arbitration, reversal muxing and the result register stay in shift_arbiter.

Test Plan:
- Single request, logical: req0 a=0x8000_00F0, b=4, arith=0, left=0. Expect req_ready[0]=1 same cycle; next cycle rsp_valid=2'b01, rsp_id=0, rsp_data=0x0800_000F.
- Arithmetic and left: req1 a=0x8000_00F0, b=4, arith=1. Expect rsp_data=0xF800_000F. Then req1 left=1, arith=1, b=8. Expect rsp_data=0x0000_F000.
- Contention, RR: both valid continuously, rsp_ready=2'b11. Expect grants 0,1,0,1 on consecutive cycles and rsp_id alternating with 1-cycle latency. With ROUND_ROBIN=0, requester 0 is granted every cycle and requester 1 starves.
- Backpressure: result for req0 pending with rsp_ready[0]=0 for 3 cycles and req1 valid. Expect req_ready=0 and rsp_data stable for 3 cycles. rsp_ready[1]=1 meanwhile has no effect. On rsp_ready[0]=1, req1 is granted in the same cycle and its result follows next cycle.
- Boundaries: b=0, a=0x1234_5678 → 0x1234_5678. b=31 arith on a=0x8000_0000 → 0xFFFF_FFFF. b=31 left on a=1 → 0x8000_0000.
- Reset mid-operation: assert rst while rsp_valid=2'b10. Expect rsp_valid=0 immediately (async), pointer back to 0, and after release a simultaneous request from both requesters is granted to requester 0 first.
